// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one memory port between the I- and D-cache line interfaces
module mem_arbiter #(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_mem_read,
  input  logic              i_mem_write,
  input  logic [ADDR_W-1:0] i_mem_addr,
  input  logic [DATA_W-1:0] i_mem_wdata,
  output logic              i_mem_ready,
  output logic [DATA_W-1:0] i_mem_rdata,
  input  logic              d_mem_read,
  input  logic              d_mem_write,
  input  logic [ADDR_W-1:0] d_mem_addr,
  input  logic [DATA_W-1:0] d_mem_wdata,
  output logic              d_mem_ready,
  output logic [DATA_W-1:0] d_mem_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata
);
  typedef enum logic [2:0] {IDLE, GRANT_I, GRANT_D, DONE_I, DONE_D} state_t;
  state_t state, state_n;
  logic last_d, req_i, req_d, pick_d, grant, fin;
  assign req_i = i_mem_read | i_mem_write;
  assign req_d = d_mem_read | d_mem_write;
  // D wins only when I is idle or I was served last
  assign pick_d = req_d & (~req_i | ~last_d);
  assign grant = (state == IDLE) & (req_i | req_d);
  assign fin = ((state == GRANT_I) | (state == GRANT_D)) & mem_ready;
  assign i_mem_ready = state == DONE_I;
  assign d_mem_ready = state == DONE_D;
  always_comb begin
    state_n = IDLE;
    case (state)
      IDLE:    state_n = grant ? (pick_d ? GRANT_D : GRANT_I) : IDLE;
      GRANT_I: state_n = mem_ready ? DONE_I : GRANT_I;
      GRANT_D: state_n = mem_ready ? DONE_D : GRANT_D;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      last_d      <= 1'b1;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      i_mem_rdata <= '0;
      d_mem_rdata <= '0;
    end else begin
      state <= state_n;
      if (grant) begin
        last_d    <= pick_d;
        mem_write <= pick_d ? d_mem_write : i_mem_write;
        mem_read  <= pick_d ? d_mem_read & ~d_mem_write : i_mem_read & ~i_mem_write;
        mem_addr  <= pick_d ? d_mem_addr : i_mem_addr;
        mem_wdata <= pick_d ? d_mem_wdata : i_mem_wdata;
      end
      if (fin) begin
        mem_read  <= 1'b0;
        mem_write <= 1'b0;
        if (state == GRANT_I) i_mem_rdata <= mem_rdata;
        else d_mem_rdata <= mem_rdata;
      end
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: random two-requester traffic against a transaction/timeline model of the arbiter
module tb_mem_arbiter;
  localparam int AW = 28, DW = 128;
  logic clk = 0, rst = 1;
  logic i_mem_read, i_mem_write, d_mem_read, d_mem_write;
  logic [AW-1:0] i_mem_addr, d_mem_addr, mem_addr;
  logic [DW-1:0] i_mem_wdata, d_mem_wdata, mem_wdata, i_mem_rdata, d_mem_rdata;
  logic i_mem_ready, d_mem_ready, mem_read, mem_write;
  logic mem_ready = 0;
  logic [DW-1:0] mem_rdata = '0;
  logic rq_rd[2], rq_wr[2], pend[2];
  logic [AW-1:0] rq_ad[2];
  logic [DW-1:0] rq_wd[2];
  int n_chk = 0, n_pass = 0, n_done = 0;
  // model: in-flight transaction, expected pulse cycle, first cycle whose closing edge may grant
  logic tx_act, tx_wr, pulse_wr, last_d;
  int tx_s, pulse_s, pulse_at, free_at;
  logic [AW-1:0] tx_ad;
  logic [DW-1:0] tx_wd, pulse_dat;
  assign i_mem_read = rq_rd[0];
  assign i_mem_write = rq_wr[0];
  assign i_mem_addr = rq_ad[0];
  assign i_mem_wdata = rq_wd[0];
  assign d_mem_read = rq_rd[1];
  assign d_mem_write = rq_wr[1];
  assign d_mem_addr = rq_ad[1];
  assign d_mem_wdata = rq_wd[1];
  always #5 clk = ~clk;
  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .i_mem_read(i_mem_read), .i_mem_write(i_mem_write), .i_mem_addr(i_mem_addr),
    .i_mem_wdata(i_mem_wdata), .i_mem_ready(i_mem_ready), .i_mem_rdata(i_mem_rdata),
    .d_mem_read(d_mem_read), .d_mem_write(d_mem_write), .d_mem_addr(d_mem_addr),
    .d_mem_wdata(d_mem_wdata), .d_mem_ready(d_mem_ready), .d_mem_rdata(d_mem_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );
  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  function automatic logic [DW-1:0] rnd_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction
  initial begin
    for (int s = 0; s < 2; s++) begin
      rq_rd[s] = 0; rq_wr[s] = 0; pend[s] = 0; rq_ad[s] = '0; rq_wd[s] = '0;
    end
    tx_act = 0; tx_wr = 0; tx_s = 0; tx_ad = '0; tx_wd = '0;
    pulse_at = -1; pulse_s = 0; pulse_wr = 0; pulse_dat = '0; last_d = 1; free_at = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_mem_read", mem_read, 0);
    chk("rst_mem_write", mem_write, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_i_ready", i_mem_ready, 0);
    chk("rst_d_ready", d_mem_ready, 0);
    chk("rst_i_rdata", i_mem_rdata, 0);
    rst = 0;
    for (int c = 0; c < 3000; c++) begin
      chk("mem_read", mem_read, tx_act && !tx_wr);
      chk("mem_write", mem_write, tx_act && tx_wr);
      if (tx_act) begin
        chk("mem_addr", mem_addr, tx_ad);
        chk("mem_wdata", mem_wdata, tx_wd);
      end
      chk("i_ready", i_mem_ready, pulse_at == c && pulse_s == 0);
      chk("d_ready", d_mem_ready, pulse_at == c && pulse_s == 1);
      if (pulse_at == c && !pulse_wr)
        chk(pulse_s ? "d_rdata" : "i_rdata", pulse_s ? d_mem_rdata : i_mem_rdata, pulse_dat);
      rst = 0;
      // requesters: drop on ready, then start new requests (always early on, to force contention)
      for (int s = 0; s < 2; s++) begin
        if (s == 0 ? i_mem_ready : d_mem_ready) begin
          pend[s] = 0; rq_rd[s] = 0; rq_wr[s] = 0; n_done++;
        end
        if (!pend[s] && (c < 200 || $urandom_range(0, 3) == 0)) begin
          int rw;
          rw = $urandom_range(1, 3);
          pend[s] = 1; rq_rd[s] = rw[0]; rq_wr[s] = rw[1];
          rq_ad[s] = AW'($urandom); rq_wd[s] = rnd_line();
        end
      end
      mem_ready = $urandom_range(0, 2) == 0;
      mem_rdata = rnd_line();
      if (c >= 300 && $urandom_range(0, 99) == 0) begin
        rst = 1;
        #1;
        chk("arst_mem_read", mem_read, 0);
        chk("arst_mem_write", mem_write, 0);
        chk("arst_i_ready", i_mem_ready, 0);
        chk("arst_d_ready", d_mem_ready, 0);
        tx_act = 0; pulse_at = -1; last_d = 1; free_at = c + 1;
      end else if (tx_act && mem_ready) begin
        tx_act = 0; pulse_at = c + 1; pulse_s = tx_s; pulse_wr = tx_wr;
        pulse_dat = mem_rdata; free_at = c + 2;
      end else if (!tx_act && c >= free_at && (pend[0] || pend[1])) begin
        tx_s = (pend[0] && pend[1]) ? (last_d ? 0 : 1) : (pend[1] ? 1 : 0);
        tx_act = 1; tx_wr = rq_wr[tx_s]; tx_ad = rq_ad[tx_s]; tx_wd = rq_wd[tx_s];
        last_d = tx_s == 1;
      end
      @(negedge clk);
    end
    chk("progress", n_done >= 50, 1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
